// File: rtl/cic_pkg.sv
// Shared helpers for the CIC comb chain: sign extension, channel index width
// and the rounding constant used when narrowing the result.
package cic_pkg;

  function automatic int chan_width(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  // Replicates bit iw-1 into every higher bit; callers size-cast the result.
  function automatic logic [63:0] sext(input logic [63:0] x, input int iw);
    logic [63:0] r;
    r = x;
    for (int b = 0; b < 64; b++) begin
      if (b >= iw) r[b] = x[iw-1];
    end
    return r;
  endfunction

  function automatic logic [63:0] round_const(input int ow, input int rw);
    return (ow > rw) ? (64'd1 << (ow - rw - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb stage y = x - x[n-M] with M-deep history kept separately per channel,
// plus the valid/channel pipeline register that travels alongside the data.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int OW  = 16,
  parameter int M   = 1,
  parameter int NCH = 1,
  localparam int CW = chan_width(NCH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic [CW-1:0] chan_in,
  input  logic [OW-1:0] data_in,
  output logic          valid_out,
  output logic [CW-1:0] chan_out,
  output logic [OW-1:0] data_out
);

  logic [OW-1:0] hist [NCH][M];

  // Only the firing channel's history shifts; the other channels keep theirs.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      chan_out  <= '0;
      data_out  <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int j = 0; j < M; j++) begin
          hist[c][j] <= '0;
        end
      end
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out           <= data_in - hist[chan_in][M-1];
        chan_out           <= chan_in;
        hist[chan_in][0]   <= data_in;
        for (int j = 1; j < M; j++) begin
          hist[chan_in][j] <= hist[chan_in][j-1];
        end
      end
    end
  end

endmodule

// File: rtl/cic_comb_chain.sv
// Multi-channel CIC comb section: NS cascaded combs, registered channel-tagged output.
// Define CIC_COMB_ROUND_EN to round half up (instead of truncate) when narrowing to RW bits.
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int IW  = 10,
  parameter int OW  = 16,
  parameter int RW  = 12,
  parameter int NS  = 3,
  parameter int M   = 1,
  parameter int NCH = 1,
  localparam int CW = chan_width(NCH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_first,
  input  logic [IW-1:0] i_data,
  output logic [RW-1:0] o_data,
  output logic [CW-1:0] o_chan,
  output logic          o_ready
);

  logic [CW-1:0] chan_cnt;
  logic [CW-1:0] cur_chan;
  logic [CW-1:0] next_chan;

  logic [OW-1:0] stage_data  [NS+1];
  logic          stage_valid [NS+1];
  logic [CW-1:0] stage_chan  [NS+1];

  logic [RW-1:0] reduced;

  // i_first only matters together with i_ce, so it can steer cur_chan unconditionally.
  always_comb begin
    cur_chan  = i_first ? '0 : chan_cnt;
    next_chan = (cur_chan == CW'(NCH - 1)) ? '0 : cur_chan + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      chan_cnt <= '0;
    end else if (i_ce) begin
      chan_cnt <= next_chan;
    end
  end

  assign stage_data[0]  = OW'(sext(64'(i_data), IW));
  assign stage_valid[0] = i_ce;
  assign stage_chan[0]  = cur_chan;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    cic_comb_stage #(
      .OW (OW),
      .M  (M),
      .NCH(NCH)
    ) u_stage (
      .clk      (i_clk),
      .reset    (i_reset),
      .valid_in (stage_valid[k]),
      .chan_in  (stage_chan[k]),
      .data_in  (stage_data[k]),
      .valid_out(stage_valid[k+1]),
      .chan_out (stage_chan[k+1]),
      .data_out (stage_data[k+1])
    );
  end

`ifdef CIC_COMB_ROUND_EN
  localparam logic [OW-1:0] RND = OW'(round_const(OW, RW));
  logic [OW-1:0] narrow_src;
  assign narrow_src = stage_data[NS] + RND;
`else
  logic [OW-1:0] narrow_src;
  assign narrow_src = stage_data[NS];
`endif

  assign reduced = narrow_src[OW-1 -: RW];

  // The dropped LSBs are intentionally discarded.
  if (RW < OW) begin : g_drop
    logic unused_lsbs;
    assign unused_lsbs = ^narrow_src[OW-RW-1:0];
  end

  // Data and channel hold between strobes; only o_ready returns to 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data  <= '0;
      o_chan  <= '0;
      o_ready <= 1'b0;
    end else begin
      o_ready <= stage_valid[NS];
      if (stage_valid[NS]) begin
        o_data <= reduced;
        o_chan <= stage_chan[NS];
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_chain.sv
// Directed + random bench for cic_comb_chain (NS=2, M=2, NCH=2) using a
// closed-form comb model y = x[n] - 2x[n-2] + x[n-4] per channel and a result queue.
module tb_cic_comb_chain;

  localparam int IW  = 9;
  localparam int OW  = 10;
  localparam int RW  = 8;
  localparam int NS  = 2;
  localparam int M   = 2;
  localparam int NCH = 2;

  logic          i_clk   = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_ce    = 1'b0;
  logic          i_first = 1'b0;
  logic [IW-1:0] i_data  = '0;
  logic [RW-1:0] o_data;
  logic [0:0]    o_chan;
  logic          o_ready;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic [RW-1:0] data;
    logic [0:0]    chan;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [OW-1:0] xh [NCH][5];
  int            model_chan = 0;
  logic [RW-1:0] held_data  = '0;
  logic [0:0]    held_chan  = '0;
  int            pat [5]    = '{255, 0, -256, 0, 255};

  cic_comb_chain #(
    .IW (IW),
    .OW (OW),
    .RW (RW),
    .NS (NS),
    .M  (M),
    .NCH(NCH)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_ce   (i_ce),
    .i_first(i_first),
    .i_data (i_data),
    .o_data (o_data),
    .o_chan (o_chan),
    .o_ready(o_ready)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; the model is updated as the sample is driven.
  task automatic applyStimulus(input logic rst, input logic ce, input logic first, input int d);
    int            c;
    logic [OW-1:0] e;
    @(posedge i_clk);
    #1;
    i_reset = rst;
    i_ce    = ce;
    i_first = first;
    i_data  = IW'(d);
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++)
        for (int k = 0; k < 5; k++) xh[ch][k] = '0;
      model_chan = 0;
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    end else if (ce) begin
      c          = first ? 0 : model_chan;
      model_chan = (c + 1) % NCH;
      for (int k = 4; k > 0; k--) xh[c][k] = xh[c][k-1];
      xh[c][0] = OW'(d);
      e = xh[c][0] - (xh[c][2] << 1) + xh[c][4];
`ifdef CIC_COMB_ROUND_EN
      e = e + OW'(1 << (OW - RW - 1));
`endif
      sb.push_back('{e[OW-1 -: RW], 1'(c), cyc + NS + 1});
    end
  endtask

  // Output monitor: pops on every strobe, checks hold values otherwise.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_ready) begin
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("[TB] FAIL spurious_ready: got o_ready=1 required no pending result");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("data", 32'(o_data), 32'(e.data));
        checkOutput("chan", 32'(o_chan), 32'(e.chan));
        checkOutput("latency", 32'(cyc), 32'(e.due));
        held_data = e.data;
        held_chan = e.chan;
      end
    end else begin
      checkOutput("hold_data", 32'(o_data), 32'(held_data));
      checkOutput("hold_chan", 32'(o_chan), 32'(held_chan));
      vectors++;
      assert (!(sb.size() > 0 && sb[0].due <= cyc)) else begin
        miscompares++;
        $error("[TB] FAIL missing_ready: got o_ready=0 required 1 at cycle %0d", cyc);
      end
      if (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
    end
    if (i_reset) begin
      held_data = '0;
      held_chan = '0;
    end
  end

  initial begin
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < 5; k++) xh[ch][k] = '0;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge i_clk);
    checkOutput("reset_data", 32'(o_data), 32'd0);
    checkOutput("reset_chan", 32'(o_chan), 32'd0);
    checkOutput("reset_ready", 32'(o_ready), 32'd0);

    // Interleaved: ch0 constant 40, ch1 impulse -12, back-to-back.
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1, (i == 0), (i % 2 == 0) ? 40 : ((i == 1) ? -12 : 0));

    // Sparse i_ce: spacing must be preserved at the output.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 3 * i - 7);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end

    // Realign on a sample the counter thinks is ch1, then i_first without i_ce.
    applyStimulus(0, 1, 0, 17);
    applyStimulus(0, 1, 1, -9);
    applyStimulus(0, 0, 1, 55);
    applyStimulus(0, 1, 0, 21);

    // Wrap-around: 255 - 2*(-256) + 255 overflows 10 bits on both channels.
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, (i == 0), pat[i/2]);

    // Values whose dropped LSBs distinguish truncation from rounding.
    applyStimulus(0, 1, 0, 7);
    applyStimulus(0, 1, 0, -5);
    applyStimulus(0, 1, 0, 13);
    applyStimulus(0, 1, 0, 6);

    // Reset with two samples in flight and i_ce also high.
    applyStimulus(0, 1, 0, 100);
    applyStimulus(0, 1, 0, -77);
    applyStimulus(1, 1, 0, 33);
    applyStimulus(0, 0, 0, 0);
    @(negedge i_clk);
    checkOutput("post_reset_data", 32'(o_data), 32'd0);
    checkOutput("post_reset_chan", 32'(o_chan), 32'd0);
    checkOutput("post_reset_ready", 32'(o_ready), 32'd0);
    applyStimulus(0, 1, 0, 20);
    applyStimulus(0, 1, 0, -31);

    for (int i = 0; i < 40; i++)
      applyStimulus(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 511)) - 256);

    repeat (NS + 4) applyStimulus(0, 0, 0, 0);
    @(negedge i_clk);
    checkOutput("drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
